// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO responder: decodes frames from synchronised mdc/mdio_in, strobes the register bank, drives read data.
// Optional MDIO_PREAMBLE_EN: require >=32 consecutive ones in IDLE before a start bit is accepted.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  output logic        rd_req,
  input  logic [15:0] rd_data,
  output logic        frame_err
);

  // state     | meaning
  // S_IDLE    | waiting for the first ST bit (0)
  // S_START   | bit1 seen, waiting for ST bit2 (1)
  // S_HEADER  | shifting OP, PHYAD, REGAD (bits 3..14)
  // S_TA      | turnaround bits 15..16
  // S_WR_DATA | shifting write data bits 17..32
  // S_RD_DATA | driving read data toward the controller
  // S_SKIP    | frame not for us or illegal; count out to bit 32
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HEADER, S_TA, S_WR_DATA, S_RD_DATA, S_SKIP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic                   mdc_prev_q, mdc_prev_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [14:0]            sr_q, sr_d;
  logic                   is_rd_q, is_rd_d;
  logic                   rd_cap_q, rd_cap_d;
  logic [15:0]            rd_buf_q, rd_buf_d;
  logic [4:0]             addr_q, addr_d;
  logic [15:0]            wr_data_q, wr_data_d;
  logic                   wr_stb_q, wr_stb_d;
  logic                   rd_req_q, rd_req_d;
  logic                   frame_err_q, frame_err_d;
  logic                   oe_q, oe_d;
  logic                   out_q, out_d;
`ifdef MDIO_PREAMBLE_EN
  logic [5:0]             pre_cnt_q, pre_cnt_d;
`endif

  logic       mdc_s, bit_s, mdc_rise, mdc_fall;
  logic [1:0] op_w;
  logic [4:0] phyad_w, regad_w;

  assign mdc_s    = mdc_sync_q[SYNC_STAGES-1];
  assign bit_s    = mdio_sync_q[SYNC_STAGES-1];
  assign mdc_rise = mdc_s & ~mdc_prev_q;
  assign mdc_fall = ~mdc_s & mdc_prev_q;
  // sr_q holds previously received bits with the most recent in bit 0
  assign op_w     = {sr_q[0], bit_s};
  assign phyad_w  = sr_q[8:4];
  assign regad_w  = {sr_q[3:0], bit_s};

  always_comb begin
    state_d     = state_q;
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc};
    mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_in};
    mdc_prev_d  = mdc_s;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    is_rd_d     = is_rd_q;
    rd_cap_d    = rd_req_q;
    rd_buf_d    = rd_cap_q ? rd_data : rd_buf_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    rd_req_d    = 1'b0;
    frame_err_d = 1'b0;
    oe_d        = oe_q;
    out_d       = out_q;
`ifdef MDIO_PREAMBLE_EN
    pre_cnt_d   = pre_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (mdc_rise) begin
`ifdef MDIO_PREAMBLE_EN
          if (bit_s) begin
            pre_cnt_d = (pre_cnt_q == 6'd63) ? pre_cnt_q : pre_cnt_q + 6'd1;
          end else if (pre_cnt_q >= 6'd32) begin
            state_d = S_START;
            cnt_d   = 5'd1;
          end else begin
            pre_cnt_d = 6'd0;
          end
`else
          if (!bit_s) begin
            state_d = S_START;
            cnt_d   = 5'd1;
          end
`endif
        end
      end
      S_START: begin
        if (mdc_rise) begin
          if (bit_s) begin
            state_d = S_HEADER;
            cnt_d   = 5'd2;
          end else begin
            cnt_d = 5'd1;
          end
        end
      end
      S_HEADER: begin
        if (mdc_rise) begin
          cnt_d = cnt_q + 5'd1;
          sr_d  = {sr_q[13:0], bit_s};
          if (cnt_q == 5'd3) begin
            is_rd_d = (op_w == 2'b10);
            if (op_w == 2'b00 || op_w == 2'b11) begin
              frame_err_d = 1'b1;
              state_d     = S_SKIP;
            end
          end else if (cnt_q == 5'd13) begin
            if (phyad_w != PHY_ADDR) begin
              state_d = S_SKIP;
            end else begin
              addr_d   = regad_w;
              rd_req_d = is_rd_q;
              state_d  = S_TA;
            end
          end
        end
      end
      S_TA: begin
        if (mdc_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) state_d = is_rd_q ? S_RD_DATA : S_WR_DATA;
        end else if (mdc_fall && cnt_q == 5'd15 && is_rd_q) begin
          oe_d  = 1'b1;
          out_d = 1'b0;
        end
      end
      S_WR_DATA: begin
        if (mdc_rise) begin
          cnt_d = cnt_q + 5'd1;
          sr_d  = {sr_q[13:0], bit_s};
          if (cnt_q == 5'd31) begin
            wr_data_d = {sr_q, bit_s};
            wr_stb_d  = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_RD_DATA: begin
        if (mdc_rise) begin
          cnt_d = cnt_q + 5'd1;
        end else if (mdc_fall) begin
          // counter has wrapped to 0 once rise 32 has been seen
          if (cnt_q == 5'd0) begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            out_d    = rd_buf_q[15];
            rd_buf_d = {rd_buf_q[14:0], 1'b0};
          end
        end
      end
      S_SKIP: begin
        if (mdc_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MDIO_PREAMBLE_EN
    if (state_d == S_IDLE && state_q != S_IDLE) pre_cnt_d = 6'd0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      cnt_q       <= 5'd0;
      sr_q        <= '0;
      is_rd_q     <= 1'b0;
      rd_cap_q    <= 1'b0;
      rd_buf_q    <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_stb_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
      pre_cnt_q   <= 6'd0;
`endif
    end else begin
      state_q     <= state_d;
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      is_rd_q     <= is_rd_d;
      rd_cap_q    <= rd_cap_d;
      rd_buf_q    <= rd_buf_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      rd_req_q    <= rd_req_d;
      frame_err_q <= frame_err_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
`ifdef MDIO_PREAMBLE_EN
      pre_cnt_q   <= pre_cnt_d;
`endif
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign wr_stb    = wr_stb_q;
  assign rd_req    = rd_req_q;
  assign frame_err = frame_err_q;

endmodule
